// File: rtl/up_down_sat.sv
// Saturating up/down counter with enable and synchronous reset.
// Ports: clk, rst (sync, active-high), dir (1=up), en, count[WIDTH-1:0].
// Define UPDOWNSAT_WRAP_EN for modular (wrapping) counting instead of clamping.
module up_down_sat #(
  parameter int WIDTH = 3
) (
  input  logic             dir,
  input  logic             en,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MIN = '0;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] count_nxt;

  assign at_max    = (count == MAX);
  assign at_min    = (count == MIN);
  assign count_inc = count + ONE;
  assign count_dec = count - ONE;

`ifdef UPDOWNSAT_WRAP_EN
  // Modular: natural width truncation wraps max->0 and 0->max.
  always_comb begin
    count_nxt = count;
    if (en) begin
      if (dir) count_nxt = count_inc;
      else     count_nxt = count_dec;
    end
  end
`else
  // Saturating: hold at the limit instead of stepping past it.
  always_comb begin
    count_nxt = count;
    if (en) begin
      if (dir) begin
        if (!at_max) count_nxt = count_inc;
      end else begin
        if (!at_min) count_nxt = count_dec;
      end
    end
  end
`endif

  // Reset wins over everything, so X on en/dir cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

// File: tb/tb_up_down_sat.sv
// Directed bench for up_down_sat, WIDTH=3, saturating build.
// Table of per-edge vectors plus short hand-written corner sequences.
module tb_up_down_sat;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [2:0] count;

  int tests;
  int fails;

  up_down_sat #(.WIDTH(3)) dut (
    .dir  (dir),
    .en   (en),
    .clk  (clk),
    .rst  (rst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input logic r, input logic e,
                      input logic d);
    @(negedge clk);
    rst = r;
    en  = e;
    dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [2:0] exp);
    tests++;
    if (count !== exp) begin
      fails++;
      $display("FAIL %s: count=%0d expected=%0d",
               name, count, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;

    // reset
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0});
    // count up and saturate
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1'b0, 1'b1, 1'b1,
                       3'(i > 7 ? 7 : i)});
    // count down and saturate
    for (int i = 6; i >= -2; i--)
      vecs.push_back('{1'b0, 1'b1, 1'b0,
                       3'(i < 0 ? 0 : i)});
    // enable hold
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd3});
    // reset priority while counting up
    vecs.push_back('{1'b1, 1'b1, 1'b1, 3'd0});
    // reset priority while counting down
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0});
    // counting resumes right after reset
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd1});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].dir);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // same-edge direction reversal: 1 -> 2 -> 1 -> 2
    step(1'b0, 1'b1, 1'b1);
    check("rev_up", 3'd2);
    step(1'b0, 1'b1, 1'b0);
    check("rev_down", 3'd1);
    step(1'b0, 1'b1, 1'b1);
    check("rev_up2", 3'd2);

    // long hold at max
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    check("reach_max", 3'd7);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("hold_max%0d", i), 3'd7);
    end

    // reset from max while counting down
    step(1'b1, 1'b1, 1'b0);
    check("rst_from_max", 3'd0);

    // long hold at zero
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check($sformatf("hold_min%0d", i), 3'd0);
    end

    // unknown en/dir under reset still yields zero
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("pre_x", 3'd2);
    step(1'b1, 1'bx, 1'bx);
    check("rst_x", 3'd0);

    // input glitches between edges are ignored
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    dir = 1'b1;
    #2;
    en  = 1'b0;
    #1;
    check("no_comb_path", 3'd0);
    @(posedge clk);
    #1;
    check("glitch_hold", 3'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
